genius_round_ctrl: RTL and testbench

GENIUS_ROUND_CTRL -- requirements
Module: genius_round_ctrl

---
 rtl/genius_pkg.sv | 26 ++
 rtl/genius_btn_edge.sv | 38 +++
 rtl/genius_round_ctrl.sv | 141 ++++++++++++++
 tb/tb_genius_round_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius memory-game round controller:
// FSM state encoding, colour codes and default timing parameters.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_BTN,
    ST_WAIT_REL,
    ST_NEXT_LEVEL,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam logic [1:0] COLOUR_0       = 2'd0;
  localparam logic [1:0] COLOUR_1       = 2'd1;
  localparam logic [1:0] COLOUR_2       = 2'd2;
  localparam logic [1:0] COLOUR_INVALID = 2'd3;

  localparam int DEF_ON_TICKS      = 4;
  localparam int DEF_OFF_TICKS     = 2;
  localparam int DEF_TIMEOUT_TICKS = 20;
  localparam int DEF_MAX_LEVEL     = 15;

endpackage

// File: rtl/genius_btn_edge.sv
// Player button press detector: keeps the previous button sample and
// reports a new press together with its decoded colour.
module genius_btn_edge
  import genius_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] i_btn,
  output logic       o_press,
  output logic       o_oneHot,
  output logic [1:0] o_colour
);

  logic [2:0] r_btnPrev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_btnPrev <= 3'b000;
    end else begin
      r_btnPrev <= i_btn;
    end
  end

  // A press only counts when every button was released the cycle before.
  assign o_press = (i_btn != 3'b000) && (r_btnPrev == 3'b000);

  always_comb begin
    o_oneHot = 1'b1;
    o_colour = COLOUR_INVALID;
    case (i_btn)
      3'b001:  o_colour = COLOUR_0;
      3'b010:  o_colour = COLOUR_1;
      3'b100:  o_colour = COLOUR_2;
      default: o_oneHot = 1'b0;
    endcase
  end

endmodule

// File: rtl/genius_round_ctrl.sv
// Genius round controller: shows the colour sequence for the current level,
// then checks the player's presses against it, advancing to WIN or LOSE.
module genius_round_ctrl
  import genius_pkg::*;
#(
  parameter int ON_TICKS      = DEF_ON_TICKS,
  parameter int OFF_TICKS     = DEF_OFF_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int MAX_LEVEL     = DEF_MAX_LEVEL
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [2:0] btn,
  input  logic [1:0] seq_value,
  output logic [3:0] seq_addr,
  output logic [3:0] level,
  output logic       show_valid,
  output logic [1:0] show_value,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam logic [7:0] ON_LAST      = 8'(ON_TICKS - 1);
  localparam logic [7:0] OFF_LAST     = 8'(OFF_TICKS - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);
  localparam logic [3:0] LEVEL_LAST   = 4'(MAX_LEVEL);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_timer;
  logic [3:0] r_seqAddr;
  logic [3:0] w_nextAddr;
  logic [3:0] r_level;
  logic [3:0] w_nextLevel;
  logic       r_startPrev;
  logic       w_startEdge;
  logic       w_press;
  logic       w_oneHot;
  logic [1:0] w_colour;

  genius_btn_edge u_btnEdge (
    .clock    (clock),
    .reset    (reset),
    .i_btn    (btn),
    .o_press  (w_press),
    .o_oneHot (w_oneHot),
    .o_colour (w_colour)
  );

  assign w_startEdge = start && !r_startPrev;

  always_comb begin
    w_nextState = r_state;
    w_nextAddr  = r_seqAddr;
    w_nextLevel = r_level;
    case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (w_startEdge) begin
          w_nextState = ST_SHOW_ON;
          w_nextAddr  = 4'd0;
          w_nextLevel = 4'd0;
        end
      end
      ST_SHOW_ON: begin
        if (tick && r_timer == ON_LAST) w_nextState = ST_SHOW_OFF;
      end
      ST_SHOW_OFF: begin
        if (tick && r_timer == OFF_LAST) begin
          if (r_seqAddr == r_level) begin
            w_nextAddr  = 4'd0;
            w_nextState = ST_WAIT_BTN;
          end else begin
            w_nextAddr  = r_seqAddr + 4'd1;
            w_nextState = ST_SHOW_ON;
          end
        end
      end
      ST_WAIT_BTN: begin
        // A press landing on the final timeout tick still gets judged.
        if (w_press) begin
          w_nextState = (w_oneHot && w_colour == seq_value) ? ST_WAIT_REL : ST_LOSE;
        end else if (tick && r_timer == TIMEOUT_LAST) begin
          w_nextState = ST_LOSE;
        end
      end
      ST_WAIT_REL: begin
        if (btn == 3'b000) begin
          if (r_seqAddr == r_level) begin
            w_nextState = ST_NEXT_LEVEL;
          end else begin
            w_nextAddr  = r_seqAddr + 4'd1;
            w_nextState = ST_WAIT_BTN;
          end
        end
      end
      ST_NEXT_LEVEL: begin
        if (r_level == LEVEL_LAST) begin
          w_nextState = ST_WIN;
        end else begin
          w_nextLevel = r_level + 4'd1;
          w_nextAddr  = 4'd0;
          w_nextState = ST_SHOW_ON;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The timer restarts on every state change so each phase measures from its entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= 8'd0;
      r_seqAddr   <= 4'd0;
      r_level     <= 4'd0;
      r_startPrev <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_seqAddr   <= w_nextAddr;
      r_level     <= w_nextLevel;
      r_startPrev <= start;
      if (w_nextState != r_state) begin
        r_timer <= 8'd0;
      end else if (tick && r_timer != 8'hFF) begin
        r_timer <= r_timer + 8'd1;
      end
    end
  end

  assign seq_addr   = r_seqAddr;
  assign level      = r_level;
  assign show_valid = (r_state == ST_SHOW_ON);
  assign show_value = show_valid ? seq_value : COLOUR_0;
  assign busy       = !(r_state == ST_IDLE || r_state == ST_WIN || r_state == ST_LOSE);
  assign win        = (r_state == ST_WIN);
  assign lose       = (r_state == ST_LOSE);

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Directed bench for genius_round_ctrl with ON=2, OFF=1, TIMEOUT=5, MAX_LEVEL=1,
// tick every cycle and a sequence store holding {2,1}.
module tb_genius_round_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       tick;
  logic [2:0] btn;
  logic [1:0] seq_value;
  logic [3:0] seq_addr;
  logic [3:0] level;
  logic       show_valid;
  logic [1:0] show_value;
  logic       busy;
  logic       win;
  logic       lose;

  logic [1:0] store [16];
  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic        rst;
    logic        st;
    logic [2:0]  b;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  assign seq_value = store[seq_addr];

  genius_round_ctrl #(
    .ON_TICKS      (2),
    .OFF_TICKS     (1),
    .TIMEOUT_TICKS (5),
    .MAX_LEVEL     (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .btn        (btn),
    .seq_value  (seq_value),
    .seq_addr   (seq_addr),
    .level      (level),
    .show_valid (show_valid),
    .show_value (show_value),
    .busy       (busy),
    .win        (win),
    .lose       (lose)
  );

  // Expected outputs packed as {seq_addr, level, show_valid, show_value, busy, win, lose}.
  function automatic logic [13:0] outs(input logic [3:0] a, input logic [3:0] l, input logic sv,
                                       input logic [1:0] v, input logic bz, input logic w, input logic lo);
    return {a, l, sv, v, bz, w, lo};
  endfunction

  function automatic vec_t mkVec(input logic r, input logic s, input logic [2:0] b, input logic [13:0] e);
    vec_t x;
    x.rst = r;
    x.st  = s;
    x.b   = b;
    x.exp = e;
    return x;
  endfunction

  task automatic applyStimulus(input logic r, input logic s, input logic [2:0] b);
    reset = r;
    start = s;
    btn   = b;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [13:0] expv);
    logic [13:0] act;
    act = {seq_addr, level, show_valid, show_value, busy, win, lose};
    checkCount++;
    if (act === expv) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got addr=%0d level=%0d sv=%b val=%0d busy=%b win=%b lose=%b, expected addr=%0d level=%0d sv=%b val=%0d busy=%b win=%b lose=%b",
               name, act[13:10], act[9:6], act[5], act[4:3], act[2], act[1], act[0],
               expv[13:10], expv[9:6], expv[5], expv[4:3], expv[2], expv[1], expv[0]);
    end
  endtask

  // Start pulse then walk through the single level-0 element into WAIT_BTN.
  task automatic startGame(input string name, input logic [2:0] b);
    applyStimulus(1'b0, 1'b1, b);
    checkOutput({name, " show"}, outs(4'd0, 4'd0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0));
    applyStimulus(1'b0, 1'b0, b);
    applyStimulus(1'b0, 1'b0, b);
    applyStimulus(1'b0, 1'b0, b);
    checkOutput({name, " wait"}, outs(4'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) store[i] = 2'd0;
    store[0] = 2'd2;
    store[1] = 2'd1;
    tick  = 1'b1;
    reset = 1'b1;
    start = 1'b0;
    btn   = 3'b000;

    vecs.push_back(mkVec(1, 0, 3'b000, outs(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mkVec(0, 1, 3'b000, outs(0, 0, 1, 2, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 0, 1, 2, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b100, outs(0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 1, 1, 2, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 1, 1, 2, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(1, 1, 1, 1, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(1, 1, 1, 1, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(1, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b100, outs(0, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(1, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b010, outs(1, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(1, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(1, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(1, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(mkVec(0, 0, 3'b001, outs(1, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(mkVec(0, 1, 3'b000, outs(0, 0, 1, 2, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 0, 1, 2, 1, 0, 0)));
    vecs.push_back(mkVec(0, 1, 3'b000, outs(0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkVec(0, 0, 3'b011, outs(0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mkVec(0, 0, 3'b000, outs(0, 0, 0, 0, 0, 0, 1)));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].b);
      checkOutput($sformatf("row%0d", i), vecs[i].exp);
    end

    // Timeout: four silent ticks keep waiting, the fifth loses.
    startGame("timeout", 3'b000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("timeout before", outs(0, 0, 0, 0, 1, 0, 0));
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("timeout lose", outs(0, 0, 0, 0, 0, 0, 1));

    // Press on the fifth tick counts as a correct press; holding it never times out.
    startGame("late press", 3'b000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b0, 3'b100);
    checkOutput("late press judged", outs(0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 3'b100);
    checkOutput("held no timeout", outs(0, 0, 0, 0, 1, 0, 0));
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("release next level", outs(0, 0, 0, 0, 1, 0, 0));
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("level1 show", outs(0, 1, 1, 2, 1, 0, 0));

    // Reset mid-show with start in the same cycle.
    applyStimulus(1'b1, 1'b1, 3'b000);
    checkOutput("reset mid show", outs(0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("start ignored a", outs(0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("start ignored b", outs(0, 0, 0, 0, 0, 0, 0));

    // A button held since before WAIT_BTN is never a press, so the round times out.
    startGame("held btn", 3'b100);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 3'b100);
    checkOutput("held btn waiting", outs(0, 0, 0, 0, 1, 0, 0));
    applyStimulus(1'b0, 1'b0, 3'b100);
    checkOutput("held btn lose", outs(0, 0, 0, 0, 0, 0, 1));
    applyStimulus(1'b0, 1'b0, 3'b000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
